// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data-side SRAM responder: access-size encodings,
// response-queue entry layout and the byte-lane merge helper.
package data_sram_responder_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam int LAT_W = 4;

    typedef struct packed {
        logic             is_load;
        logic [31:0]      data;
        logic [LAT_W-1:0] cnt;
    } resp_entry_t;

    localparam int RESP_W = $bits(resp_entry_t);

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// CPU data-side SRAM-like bus (req/addr_ok/data_ok); the CPU is the master.
interface data_sram_responder_if;

    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/data_sram_responder_resp_fifo.sv
// In-order response queue; every occupied entry counts down towards its
// release cycle while waiting.
module resp_fifo
    import data_sram_responder_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int PW     = $clog2(QDEPTH)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        push,
    input  resp_entry_t push_entry,
    input  logic        pop,
    output resp_entry_t head,
    output logic        full,
    output logic        empty,
    output logic [PW:0] count
);

    localparam int CW = PW + 1;

    resp_entry_t   entries_r [QDEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    // Entry storage: load on push, otherwise decrement a nonzero countdown.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < QDEPTH; i++) begin
                entries_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (push && (wr_ptr_r == PW'(i))) begin
                    entries_r[i] <= push_entry;
                end else if (entries_r[i].cnt != {LAT_W{1'b0}}) begin
                    entries_r[i].cnt <= entries_r[i].cnt - LAT_W'(1);
                end else begin
                    entries_r[i] <= entries_r[i];
                end
            end
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            wr_ptr_r <= push ? (wr_ptr_r + PW'(1)) : wr_ptr_r;
            rd_ptr_r <= pop  ? (rd_ptr_r + PW'(1)) : rd_ptr_r;
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = entries_r[rd_ptr_r];
    assign full  = (count_r == CW'(QDEPTH));
    assign empty = (count_r == {CW{1'b0}});
    assign count = count_r;

endmodule

// File: rtl/data_sram_responder.sv
// Slave end of the CPU data SRAM-like bus: word array accessed at accept time,
// responses returned in order after a fixed latency.
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int AW      = 10,
    parameter int LATENCY = 2,
    parameter int QDEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    data_sram_responder_if.slave bus
);

    localparam int DEPTH = 2 ** AW;
    localparam int PW    = $clog2(QDEPTH);
    localparam int CW    = PW + 1;

    logic [31:0]   mem_r [0:DEPTH-1];
    logic [AW-1:0] idx_s;
    logic          accept_s;
    logic          pop_s;
    logic          full_s;
    logic          empty_s;
    logic [CW-1:0] count_s;
    resp_entry_t   push_entry_s;
    resp_entry_t   head_s;
    logic          data_ok_r;
    logic [31:0]   rdata_r;
    logic          unused_s;

    // Acceptance depends only on registered occupancy, so a pop never frees a slot in the same cycle.
    assign bus.addr_ok = resetn && (count_s < CW'(QDEPTH));
    assign accept_s    = bus.req && bus.addr_ok;
    assign idx_s       = bus.addr[AW+1:2];
    assign pop_s       = !empty_s && (head_s.cnt == {LAT_W{1'b0}});

    // Build the queue entry; loads snapshot the whole aligned word.
    always_comb begin
        push_entry_s         = '0;
        push_entry_s.is_load = !bus.wr;
        push_entry_s.data    = bus.wr ? 32'd0 : mem_r[idx_s];
        push_entry_s.cnt     = LAT_W'(LATENCY - 1);
    end

    // Data array: byte-lane store at the accept edge, contents survive reset.
    always_ff @(posedge clk) begin
        if (accept_s && bus.wr) begin
            mem_r[idx_s] <= byte_merge(mem_r[idx_s], bus.wdata, bus.wstrb);
        end
    end

    resp_fifo #(
        .QDEPTH (QDEPTH)
    ) u_resp_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (accept_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .head       (head_s),
        .full       (full_s),
        .empty      (empty_s),
        .count      (count_s)
    );

    // Response registers: one data_ok pulse per pop, rdata held between pulses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_ok_r <= 1'b0;
            rdata_r   <= 32'd0;
        end else begin
            data_ok_r <= pop_s;
            if (pop_s) begin
                rdata_r <= head_s.is_load ? head_s.data : 32'd0;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    assign bus.data_ok = data_ok_r;
    assign bus.rdata   = rdata_r;

    // Size, sub-word and aliased address bits have no effect on the array.
    assign unused_s = ^{bus.size, bus.addr[31:AW+2], bus.addr[1:0], full_s};

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench: instance A (AW=10, LATENCY=2, QDEPTH=4) and instance B (AW=6, LATENCY=4, QDEPTH=2).
module tb_data_sram_responder;
    import data_sram_responder_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    data_sram_responder_if bus_a();
    data_sram_responder_if bus_b();

    data_sram_responder #(.AW(10), .LATENCY(2), .QDEPTH(4)) u_dut_a (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_a)
    );

    data_sram_responder #(.AW(6), .LATENCY(4), .QDEPTH(2)) u_dut_b (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_b)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_a(input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
        bus_a.req   = 1'b1;
        bus_a.wr    = wr;
        bus_a.size  = wr ? SIZE_HALF : SIZE_WORD;
        bus_a.addr  = addr;
        bus_a.wdata = wdata;
        bus_a.wstrb = wstrb;
        check("addr_ok_a", {31'd0, bus_a.addr_ok}, 32'd1);
        step();
    endtask

    task automatic expect_resp_a(input string tag, input logic [31:0] exp);
        step();
        check({tag, "_dok"}, {31'd0, bus_a.data_ok}, 32'd1);
        check(tag, bus_a.rdata, exp);
    endtask

    function automatic logic [31:0] burst_exp(input int j);
        logic [31:0] v;
        v = (j < 8) ? 32'd0 : (32'hA500_0000 | 32'(j - 8));
        return v;
    endfunction

    initial begin
        resetn = 1'b1;
        bus_a.req = 1'b0; bus_a.wr = 1'b0; bus_a.size = SIZE_BYTE;
        bus_a.addr = 32'd0; bus_a.wstrb = 4'd0; bus_a.wdata = 32'd0;
        bus_b.req = 1'b0; bus_b.wr = 1'b0; bus_b.size = SIZE_BYTE;
        bus_b.addr = 32'd0; bus_b.wstrb = 4'd0; bus_b.wdata = 32'd0;
        #2;
        resetn = 1'b0;

        // Reset: requests during reset are refused and dropped
        bus_a.req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_addr_ok", {31'd0, bus_a.addr_ok}, 32'd0);
        end
        check("rst_data_ok", {31'd0, bus_a.data_ok}, 32'd0);
        check("rst_rdata", bus_a.rdata, 32'd0);
        bus_a.req = 1'b0;
        resetn = 1'b1;
        #1;
        check("rel_addr_ok", {31'd0, bus_a.addr_ok}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rel_no_dok", {31'd0, bus_a.data_ok}, 32'd0);
        end

        // 1: store then load
        drive_a(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF);
        drive_a(1'b0, 32'h0000_0040, 32'd0, 4'h0);
        bus_a.req = 1'b0;
        check("t1_early_dok", {31'd0, bus_a.data_ok}, 32'd0);
        expect_resp_a("t1_store", 32'd0);
        expect_resp_a("t1_load", 32'hDEAD_BEEF);
        step();
        check("t1_dok_low", {31'd0, bus_a.data_ok}, 32'd0);
        check("t1_rdata_hold", bus_a.rdata, 32'hDEAD_BEEF);

        // 2: byte strobe merge
        drive_a(1'b1, 32'h0000_0040, 32'h0000_AA00, 4'b0010);
        drive_a(1'b0, 32'h0000_0040, 32'd0, 4'h0);
        bus_a.req = 1'b0;
        expect_resp_a("t2_store", 32'd0);
        expect_resp_a("t2_load", 32'hDEAD_AAEF);

        // wstrb=0 store is a no-op that is still answered
        drive_a(1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 4'b0000);
        drive_a(1'b0, 32'h0000_0040, 32'd0, 4'h0);
        bus_a.req = 1'b0;
        expect_resp_a("nop_store", 32'd0);
        expect_resp_a("nop_load", 32'hDEAD_AAEF);

        // 4: full queue on instance B with req held high
        bus_b.req = 1'b1; bus_b.wr = 1'b1; bus_b.wstrb = 4'b0000;
        check("t4_ok0", {31'd0, bus_b.addr_ok}, 32'd1);
        step();
        check("t4_ok1", {31'd0, bus_b.addr_ok}, 32'd1);
        step();
        check("t4_full", {31'd0, bus_b.addr_ok}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("t4_full_hold", {31'd0, bus_b.addr_ok}, 32'd0);
            check("t4_no_dok", {31'd0, bus_b.data_ok}, 32'd0);
        end
        step();
        check("t4_pop1_dok", {31'd0, bus_b.data_ok}, 32'd1);
        check("t4_reopen", {31'd0, bus_b.addr_ok}, 32'd1);
        step();
        check("t4_pop2_dok", {31'd0, bus_b.data_ok}, 32'd1);
        check("t4_pushpop_ok", {31'd0, bus_b.addr_ok}, 32'd1);
        bus_b.req = 1'b0;
        step();
        check("t4_gap_dok", {31'd0, bus_b.data_ok}, 32'd0);

        // 5: aliasing modulo 2**(AW+2)
        drive_a(1'b1, 32'h0000_1000, 32'h1122_3344, 4'hF);
        drive_a(1'b0, 32'h0000_0000, 32'd0, 4'h0);
        bus_a.req = 1'b0;
        expect_resp_a("t5_store", 32'd0);
        expect_resp_a("t5_alias", 32'h1122_3344);

        // 3: 8 stores then 8 loads back to back, responses two cycles behind
        for (int k = 0; k < 16; k++) begin
            if (k < 8) begin
                drive_a(1'b1, 32'(4 * k), 32'hA500_0000 | 32'(k), 4'hF);
            end else begin
                drive_a(1'b0, 32'(4 * (k - 8)), 32'd0, 4'h0);
            end
            if (k >= 2) begin
                check("t3_dok", {31'd0, bus_a.data_ok}, 32'd1);
                check("t3_rdata", bus_a.rdata, burst_exp(k - 2));
            end else begin
                check("t3_lead_dok", {31'd0, bus_a.data_ok}, 32'd0);
            end
        end
        bus_a.req = 1'b0;
        for (int k = 14; k < 16; k++) begin
            expect_resp_a("t3_tail", burst_exp(k));
        end

        // 6: reset with three loads outstanding
        drive_a(1'b0, 32'h0000_0000, 32'd0, 4'h0);
        drive_a(1'b0, 32'h0000_0004, 32'd0, 4'h0);
        drive_a(1'b0, 32'h0000_0008, 32'd0, 4'h0);
        bus_a.req = 1'b0;
        check("t6_pre_dok", {31'd0, bus_a.data_ok}, 32'd1);
        check("t6_pre_rdata", bus_a.rdata, 32'hA500_0000);
        resetn = 1'b0;
        #1;
        check("t6_async_dok", {31'd0, bus_a.data_ok}, 32'd0);
        check("t6_async_rdata", bus_a.rdata, 32'd0);
        check("t6_async_ok", {31'd0, bus_a.addr_ok}, 32'd0);
        step();
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t6_no_replay", {31'd0, bus_a.data_ok}, 32'd0);
        end
        drive_a(1'b0, 32'h0000_0004, 32'd0, 4'h0);
        bus_a.req = 1'b0;
        step();
        check("t6_wait_dok", {31'd0, bus_a.data_ok}, 32'd0);
        expect_resp_a("t6_preserved", 32'hA500_0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
